signal_conflict_monitor: RTL and testbench

SIGNAL_CONFLICT_MONITOR -- requirements
Module: signal_conflict_monitor

---
 rtl/signal_conflict_monitor.sv | 138 +++++++++++++
 tb/tb_signal_conflict_monitor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/signal_conflict_monitor.sv
// Safety monitor between a traffic light controller and its lamps: passes lamp commands
// through one register stage, and on a conflict, lamp, dark or short-yellow fault latches a cause and flashes both reds.
module signal_conflict_monitor #(
  parameter int MIN_YELLOW = 3,
  parameter int DEBOUNCE   = 2,
  parameter int FLASH_HALF = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EW_RED,
  input  logic       EW_YELLOW,
  input  logic       EW_GREEN,
  input  logic       NS_RED,
  input  logic       NS_YELLOW,
  input  logic       NS_GREEN,
  input  logic       fault_clr,
  output logic       EW_RED_OUT,
  output logic       EW_YELLOW_OUT,
  output logic       EW_GREEN_OUT,
  output logic       NS_RED_OUT,
  output logic       NS_YELLOW_OUT,
  output logic       NS_GREEN_OUT,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam int FW = $clog2(2 * FLASH_HALF);
  localparam logic [DW-1:0] DEB_LIM  = DW'(DEBOUNCE);
  localparam logic [YW-1:0] Y_LIM    = YW'(MIN_YELLOW);
  localparam logic [FW-1:0] F_LAST   = FW'(2 * FLASH_HALF - 1);
  localparam logic [FW-1:0] F_HALF   = FW'(FLASH_HALF);
  localparam logic [5:0]    LAMP_RST = 6'b100_100;

  typedef enum logic {MONITOR = 1'b0, FAULT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   deb_q, deb_d;
  logic [YW-1:0]   ew_y_q, ew_y_d, ns_y_q, ns_y_d;
  logic [FW-1:0]   flash_q, flash_d;
  logic [5:0]      lamp_q, lamp_d;
  logic [2:0]      code_q, code_d;

  logic [5:0]      lamp_in;
  logic [1:0]      ew_cnt, ns_cnt;
  logic            c_conf, c_multi, c_dark, any_bad;
  logic [2:0]      bad_code;
  logic [DW-1:0]   deb_inc;
  logic            deb_trig, ew_short, ns_short;
  logic [YW-1:0]   ew_y_nxt, ns_y_nxt;
  logic [FW-1:0]   flash_nxt;
  logic            red_on;

  assign lamp_in  = {EW_RED, EW_YELLOW, EW_GREEN, NS_RED, NS_YELLOW, NS_GREEN};
  assign ew_cnt   = {1'b0, EW_RED} + {1'b0, EW_YELLOW} + {1'b0, EW_GREEN};
  assign ns_cnt   = {1'b0, NS_RED} + {1'b0, NS_YELLOW} + {1'b0, NS_GREEN};
  assign c_conf   = (EW_GREEN | EW_YELLOW) & (NS_GREEN | NS_YELLOW);
  assign c_multi  = (ew_cnt > 2'd1) | (ns_cnt > 2'd1);
  assign c_dark   = (ew_cnt == 2'd0) | (ns_cnt == 2'd0);
  assign any_bad  = c_conf | c_multi | c_dark;
  assign bad_code = c_conf ? 3'd1 : (c_multi ? 3'd2 : 3'd3);

  assign deb_inc  = deb_q + DW'(1);
  assign deb_trig = any_bad && (deb_inc >= DEB_LIM);

  // A nonzero yellow count means yellow was lit at the previous edge.
  assign ew_short = !EW_YELLOW && (ew_y_q != '0) && (ew_y_q < Y_LIM);
  assign ns_short = !NS_YELLOW && (ns_y_q != '0) && (ns_y_q < Y_LIM);
  assign ew_y_nxt = !EW_YELLOW ? '0 : ((ew_y_q == Y_LIM) ? ew_y_q : ew_y_q + YW'(1));
  assign ns_y_nxt = !NS_YELLOW ? '0 : ((ns_y_q == Y_LIM) ? ns_y_q : ns_y_q + YW'(1));

  assign flash_nxt = (flash_q == F_LAST) ? '0 : flash_q + FW'(1);
  assign red_on    = flash_nxt < F_HALF;

  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    ew_y_d  = ew_y_q;
    ns_y_d  = ns_y_q;
    flash_d = flash_q;
    lamp_d  = lamp_q;
    code_d  = code_q;
    case (state_q)
      MONITOR: begin
        lamp_d = lamp_in;
        deb_d  = any_bad ? deb_inc : '0;
        ew_y_d = ew_y_nxt;
        ns_y_d = ns_y_nxt;
        if (deb_trig || ew_short || ns_short) begin
          state_d = FAULT;
          code_d  = deb_trig ? bad_code : 3'd4;
          flash_d = '0;
          lamp_d  = LAMP_RST;
          deb_d   = '0;
          ew_y_d  = '0;
          ns_y_d  = '0;
        end
      end
      FAULT: begin
        flash_d = flash_nxt;
        lamp_d  = {red_on, 2'b00, red_on, 2'b00};
        if (fault_clr && !any_bad) begin
          state_d = MONITOR;
          code_d  = 3'd0;
          flash_d = '0;
          lamp_d  = lamp_in;
        end
      end
      default: state_d = MONITOR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MONITOR;
      deb_q   <= '0;
      ew_y_q  <= '0;
      ns_y_q  <= '0;
      flash_q <= '0;
      lamp_q  <= LAMP_RST;
      code_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      ew_y_q  <= ew_y_d;
      ns_y_q  <= ns_y_d;
      flash_q <= flash_d;
      lamp_q  <= lamp_d;
      code_q  <= code_d;
    end
  end

  assign {EW_RED_OUT, EW_YELLOW_OUT, EW_GREEN_OUT, NS_RED_OUT, NS_YELLOW_OUT, NS_GREEN_OUT} = lamp_q;
  assign fault      = (state_q == FAULT);
  assign fault_code = code_q;

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Bench for signal_conflict_monitor: directed vector table, a hand-written yellow sequence,
// and random stimulus compared with an abstract reference model.
module tb_signal_conflict_monitor;

  localparam int MIN_Y = 3;
  localparam int DEB   = 2;
  localparam int FH    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic EW_RED = 1'b0, EW_YELLOW = 1'b0, EW_GREEN = 1'b0;
  logic NS_RED = 1'b0, NS_YELLOW = 1'b0, NS_GREEN = 1'b0;
  logic fault_clr = 1'b0;
  logic EW_RED_OUT, EW_YELLOW_OUT, EW_GREEN_OUT, NS_RED_OUT, NS_YELLOW_OUT, NS_GREEN_OUT;
  logic fault;
  logic [2:0] fault_code;

  always #5 clk = ~clk;

  signal_conflict_monitor #(.MIN_YELLOW(MIN_Y), .DEBOUNCE(DEB), .FLASH_HALF(FH)) dut (
    .clk(clk), .rst(rst),
    .EW_RED(EW_RED), .EW_YELLOW(EW_YELLOW), .EW_GREEN(EW_GREEN),
    .NS_RED(NS_RED), .NS_YELLOW(NS_YELLOW), .NS_GREEN(NS_GREEN),
    .fault_clr(fault_clr),
    .EW_RED_OUT(EW_RED_OUT), .EW_YELLOW_OUT(EW_YELLOW_OUT), .EW_GREEN_OUT(EW_GREEN_OUT),
    .NS_RED_OUT(NS_RED_OUT), .NS_YELLOW_OUT(NS_YELLOW_OUT), .NS_GREEN_OUT(NS_GREEN_OUT),
    .fault(fault), .fault_code(fault_code)
  );

  // Lamp vectors are {EW_R, EW_Y, EW_G, NS_R, NS_Y, NS_G}.
  localparam logic [5:0] RR      = 6'b100_100;
  localparam logic [5:0] EWG_NSR = 6'b001_100;
  localparam logic [5:0] EWY_NSR = 6'b010_100;
  localparam logic [5:0] EWR_NSG = 6'b100_001;
  localparam logic [5:0] EWR_NSY = 6'b100_010;
  localparam logic [5:0] BOTHG   = 6'b001_001;
  localparam logic [5:0] DARK    = 6'b000_000;
  localparam logic [5:0] OFF     = 6'b000_000;

  typedef struct {
    logic [5:0] l;
    logic       c;
    logic       r;
    logic [5:0] el;
    logic       ef;
    logic [2:0] ec;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int failures = 0;

  // Reference model state: run lengths are unbounded integers, flash phase comes from fault age.
  bit         m_fault;
  int         m_code, m_bad_run, m_ew_yrun, m_ns_yrun, m_age;
  logic [5:0] m_out;

  function automatic logic [5:0] flash_pat(input int age);
    logic red;
    red = (age % (2 * FH)) < FH;
    return {red, 2'b00, red, 2'b00};
  endfunction

  task automatic model_step(input logic [5:0] l, input logic c, input logic r);
    int ew_n, ns_n, lowest;
    bit conflict, short_y;
    if (r) begin
      m_fault = 0; m_code = 0; m_bad_run = 0; m_ew_yrun = 0; m_ns_yrun = 0; m_age = 0;
      m_out = RR;
      return;
    end
    ew_n = $countones(l[5:3]);
    ns_n = $countones(l[2:0]);
    conflict = (l[4] | l[3]) & (l[1] | l[0]);
    lowest = conflict ? 1 : (ew_n > 1 || ns_n > 1) ? 2 : (ew_n == 0 || ns_n == 0) ? 3 : 0;
    if (!m_fault) begin
      m_bad_run = (lowest != 0) ? m_bad_run + 1 : 0;
      short_y = 0;
      if (l[4]) m_ew_yrun++;
      else begin
        if (m_ew_yrun > 0 && m_ew_yrun < MIN_Y) short_y = 1;
        m_ew_yrun = 0;
      end
      if (l[1]) m_ns_yrun++;
      else begin
        if (m_ns_yrun > 0 && m_ns_yrun < MIN_Y) short_y = 1;
        m_ns_yrun = 0;
      end
      if (m_bad_run >= DEB || short_y) begin
        m_fault = 1;
        m_code = (m_bad_run >= DEB) ? lowest : 4;
        m_age = 0; m_bad_run = 0; m_ew_yrun = 0; m_ns_yrun = 0;
        m_out = flash_pat(0);
      end else begin
        m_out = l;
      end
    end else if (c && lowest == 0) begin
      m_fault = 0; m_code = 0; m_bad_run = 0; m_ew_yrun = 0; m_ns_yrun = 0;
      m_out = l;
    end else begin
      m_age++;
      m_out = flash_pat(m_age);
    end
  endtask

  task automatic apply(input logic [5:0] l, input logic c, input logic r);
    {EW_RED, EW_YELLOW, EW_GREEN, NS_RED, NS_YELLOW, NS_GREEN} = l;
    fault_clr = c;
    rst = r;
    model_step(l, c, r);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] el, input logic ef, input logic [2:0] ec);
    logic [5:0] got;
    got = {EW_RED_OUT, EW_YELLOW_OUT, EW_GREEN_OUT, NS_RED_OUT, NS_YELLOW_OUT, NS_GREEN_OUT};
    checks++;
    if (got !== el || fault !== ef || fault_code !== ec) begin
      failures++;
      $display("FAIL %s: got lamps=%b fault=%b code=%0d, want lamps=%b fault=%b code=%0d",
               name, got, fault, fault_code, el, ef, ec);
    end
  endtask

  function automatic void add(input logic [5:0] l, input logic c, input logic r,
                              input logic [5:0] el, input logic ef, input logic [2:0] ec);
    vec_t v;
    v.l = l; v.c = c; v.r = r; v.el = el; v.ef = ef; v.ec = ec;
    tbl.push_back(v);
  endfunction

  logic [5:0] valid_pats [6];

  initial begin
    // Reset, then detection starts only on the first edge without reset.
    add(BOTHG,   0, 1, RR,      0, 0);
    add(BOTHG,   0, 1, RR,      0, 0);
    add(BOTHG,   0, 0, BOTHG,   0, 0);
    add(EWG_NSR, 0, 0, EWG_NSR, 0, 0);
    // Normal cycle with a full yellow; fault_clr in MONITOR is harmless.
    add(EWY_NSR, 1, 0, EWY_NSR, 0, 0);
    add(EWY_NSR, 0, 0, EWY_NSR, 0, 0);
    add(EWY_NSR, 0, 0, EWY_NSR, 0, 0);
    add(RR,      0, 0, RR,      0, 0);
    add(EWR_NSG, 0, 0, EWR_NSG, 0, 0);
    add(EWR_NSY, 0, 0, EWR_NSY, 0, 0);
    add(EWR_NSY, 0, 0, EWR_NSY, 0, 0);
    add(EWR_NSY, 0, 0, EWR_NSY, 0, 0);
    add(RR,      0, 0, RR,      0, 0);
    // Single-cycle glitch, then a real conflict.
    add(BOTHG,   0, 0, BOTHG,   0, 0);
    add(EWG_NSR, 1, 0, EWG_NSR, 0, 0);
    add(BOTHG,   0, 0, BOTHG,   0, 0);
    add(BOTHG,   0, 0, RR,      1, 1);
    for (int i = 0; i < 4; i++) add(BOTHG, 1, 0, RR,  1, 1);
    for (int i = 0; i < 5; i++) add(BOTHG, 0, 0, OFF, 1, 1);
    add(BOTHG,   0, 0, RR,      1, 1);
    add(EWG_NSR, 1, 0, EWG_NSR, 0, 0);
    // Short yellow, then reset in an off phase.
    add(EWY_NSR, 0, 0, EWY_NSR, 0, 0);
    add(EWY_NSR, 0, 0, EWY_NSR, 0, 0);
    add(RR,      0, 0, RR,      1, 4);
    for (int i = 0; i < 4; i++) add(RR, 0, 0, RR, 1, 4);
    add(RR,      0, 0, OFF,     1, 4);
    add(RR,      0, 1, RR,      0, 0);
    add(EWR_NSG, 0, 0, EWR_NSG, 0, 0);
    // Dark, multi-lamp, and dark coinciding with a short yellow.
    add(DARK,    0, 0, DARK,    0, 0);
    add(DARK,    0, 0, RR,      1, 3);
    add(RR,      1, 0, RR,      0, 0);
    add(6'b101_100, 0, 0, 6'b101_100, 0, 0);
    add(6'b101_100, 0, 0, RR,         1, 2);
    add(RR,      1, 0, RR,      0, 0);
    add(6'b010_000, 0, 0, 6'b010_000, 0, 0);
    add(DARK,    0, 0, RR,      1, 3);
    add(RR,      1, 0, RR,      0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].l, tbl[i].c, tbl[i].r);
      check($sformatf("vec%0d", i), tbl[i].el, tbl[i].ef, tbl[i].ec);
    end

    // A long yellow saturates and does not trip the short-yellow check.
    apply(RR, 0, 1);
    apply(EWG_NSR, 0, 0);
    check("ly_green", EWG_NSR, 0, 0);
    for (int i = 0; i < 6; i++) begin
      apply(EWY_NSR, 0, 0);
      check("ly_yellow", EWY_NSR, 0, 0);
    end
    apply(RR, 0, 0);
    check("ly_release", RR, 0, 0);

    valid_pats[0] = RR;      valid_pats[1] = EWG_NSR; valid_pats[2] = EWY_NSR;
    valid_pats[3] = EWR_NSG; valid_pats[4] = EWR_NSY; valid_pats[5] = RR;

    for (int i = 0; i < 3000; i++) begin
      logic [5:0] l;
      logic c, r;
      if ($urandom_range(99) < 85) l = valid_pats[$urandom_range(5)];
      else l = 6'($urandom);
      c = ($urandom_range(99) < 30);
      r = ($urandom_range(99) < 2);
      apply(l, c, r);
      check("rand", m_out, m_fault, 3'(m_code));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
